// File: rtl/gram_matrix_accum_if.sv
// Handshake and result bus for the Gram-matrix accumulator.
interface gram_matrix_accum_if #(
  parameter int N_CH  = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 20
) ();
  logic                      I_start;
  logic                      I_valid;
  logic [N_CH*DW-1:0]        I_data;
  logic                      O_ready;
  logic                      O_busy;
  logic                      O_done;
  logic                      O_ovf;
  logic [N_CH*N_CH*ACC_W-1:0] O_gram;

  modport master (
    output I_start, I_valid, I_data,
    input  O_ready, O_busy, O_done, O_ovf, O_gram
  );

  modport slave (
    input  I_start, I_valid, I_data,
    output O_ready, O_busy, O_done, O_ovf, O_gram
  );
endinterface

// File: rtl/gram_matrix_accum.sv
// Time-multiplexed Gram-matrix accumulator: G += x*x^T per sample using one
// shared multiplier that walks the upper-triangle pairs; the lower triangle
// is wired to the mirrored upper registers.
module gram_matrix_accum #(
  parameter int N_CH  = 2,
  parameter int DW    = 8,
  parameter int ACC_W = 20,
  parameter int LEN   = 16
) (
  input  logic              I_sys_clk,
  input  logic              I_sys_rst,
  gram_matrix_accum_if.slave bus
);
  localparam int P  = N_CH * (N_CH + 1) / 2;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int RW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CW = $clog2(LEN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAPT = 2'd1;
  localparam logic [1:0] S_MAC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ACC_W-1:0] SAT = {ACC_W{1'b1}};

  logic [1:0]                 state;
  logic [CW-1:0]              cnt;
  logic [PW-1:0]              pidx;
  logic [RW-1:0]              ri, cj;
  logic [N_CH-1:0][DW-1:0]    samp;
  logic [P-1:0][ACC_W-1:0]    acc;
  logic                       ovf;

  logic [2*DW-1:0]            prod;
  logic [ACC_W:0]             sum;
  logic [ACC_W-1:0]           nxt;
  logic                       sat;
  logic                       last_pair;

  // Shared multiplier and saturating adder for the current pair (ri,cj)
  always_comb begin
    prod      = {{DW{1'b0}}, samp[ri]} * {{DW{1'b0}}, samp[cj]};
    sum       = {1'b0, acc[pidx]} + {{(ACC_W + 1 - 2*DW){1'b0}}, prod};
    sat       = sum[ACC_W];
    nxt       = sat ? SAT : sum[ACC_W-1:0];
    last_pair = (pidx == PW'(P - 1));
  end

  // Frame FSM, sample capture and triangle walk with accumulation
  always_ff @(posedge I_sys_clk or posedge I_sys_rst) begin
    if (I_sys_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      pidx  <= '0;
      ri    <= '0;
      cj    <= '0;
      samp  <= '0;
      acc   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.I_start) begin
          acc   <= '0;
          ovf   <= 1'b0;
          cnt   <= '0;
          state <= S_CAPT;
        end
        S_CAPT: if (bus.I_valid) begin
          samp  <= bus.I_data;
          cnt   <= cnt + 1'b1;
          pidx  <= '0;
          ri    <= '0;
          cj    <= '0;
          state <= S_MAC;
        end
        S_MAC: begin
          acc[pidx] <= nxt;
          if (sat) ovf <= 1'b1;
          if (last_pair) begin
            state <= (cnt == CW'(LEN)) ? S_DONE : S_CAPT;
          end else begin
            pidx <= pidx + 1'b1;
            // row-major upper triangle: wrap to the diagonal of the next row
            if (cj == RW'(N_CH - 1)) begin
              ri <= ri + 1'b1;
              cj <= ri + 1'b1;
            end else begin
              cj <= cj + 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.O_ready = (state == S_CAPT);
  assign bus.O_busy  = (state != S_IDLE);
  assign bus.O_done  = (state == S_DONE);
  assign bus.O_ovf   = ovf;

  // Position of pair (i,j), i<=j, in the packed upper-triangle storage
  function automatic int tri_idx(input int i, input int j);
    return i * N_CH - (i * (i - 1)) / 2 + (j - i);
  endfunction

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_row
    for (genvar gj = 0; gj < N_CH; gj++) begin : g_col
      localparam int LO = (gi < gj) ? gi : gj;
      localparam int HI = (gi < gj) ? gj : gi;
      assign bus.O_gram[(gi*N_CH+gj)*ACC_W +: ACC_W] = acc[tri_idx(LO, HI)];
    end
  end
endmodule

// File: tb/tb_gram_matrix_accum.sv
// Directed bench for gram_matrix_accum: three configurations, scoreboarded
// expected matrices computed by a behavioural model.
module tb_gram_matrix_accum;
  logic        clk;
  logic        rst;
  logic [2:0]  st;
  logic [2:0]  vl;
  logic [23:0] dat;
  int          cyc;
  int          errors;
  int          checks;
  int          exq[$];

  gram_matrix_accum_if #(.N_CH(2), .DW(8), .ACC_W(20)) b2 ();
  gram_matrix_accum_if #(.N_CH(2), .DW(8), .ACC_W(16)) bs ();
  gram_matrix_accum_if #(.N_CH(3), .DW(8), .ACC_W(20)) b3 ();

  assign b2.I_start = st[0];
  assign b2.I_valid = vl[0];
  assign b2.I_data  = dat[15:0];
  assign bs.I_start = st[1];
  assign bs.I_valid = vl[1];
  assign bs.I_data  = dat[15:0];
  assign b3.I_start = st[2];
  assign b3.I_valid = vl[2];
  assign b3.I_data  = dat;

  gram_matrix_accum #(.N_CH(2), .DW(8), .ACC_W(20), .LEN(4)) u_d0 (
    .I_sys_clk(clk), .I_sys_rst(rst), .bus(b2));
  gram_matrix_accum #(.N_CH(2), .DW(8), .ACC_W(16), .LEN(2)) u_d1 (
    .I_sys_clk(clk), .I_sys_rst(rst), .bus(bs));
  gram_matrix_accum #(.N_CH(3), .DW(8), .ACC_W(20), .LEN(1)) u_d2 (
    .I_sys_clk(clk), .I_sys_rst(rst), .bus(b3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic rdy(input int d);
    case (d) 0: return b2.O_ready; 1: return bs.O_ready; default: return b3.O_ready; endcase
  endfunction
  function automatic logic bsy(input int d);
    case (d) 0: return b2.O_busy; 1: return bs.O_busy; default: return b3.O_busy; endcase
  endfunction
  function automatic logic dn(input int d);
    case (d) 0: return b2.O_done; 1: return bs.O_done; default: return b3.O_done; endcase
  endfunction
  function automatic logic ov(input int d);
    case (d) 0: return b2.O_ovf; 1: return bs.O_ovf; default: return b3.O_ovf; endcase
  endfunction
  function automatic int el(input int d, input int i, input int j);
    case (d)
      0:       return int'(b2.O_gram[(i*2+j)*20 +: 20]);
      1:       return int'(bs.O_gram[(i*2+j)*16 +: 16]);
      default: return int'(b3.O_gram[(i*3+j)*20 +: 20]);
    endcase
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: saturating accumulation of x*x^T, pushes n*n elements then ovf
  task automatic model(input int n, input int len, input int accw, input int smp[$]);
    longint g[3][3];
    longint mx;
    int     o;
    mx = (longint'(1) << accw) - 1;
    o  = 0;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 3; j++) g[i][j] = 0;
    for (int s = 0; s < len; s++)
      for (int i = 0; i < n; i++)
        for (int j = i; j < n; j++) begin
          g[i][j] += longint'(smp[s*n+i]) * longint'(smp[s*n+j]);
          if (g[i][j] > mx) begin g[i][j] = mx; o = 1; end
        end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        exq.push_back(int'((i <= j) ? g[i][j] : g[j][i]));
    exq.push_back(o);
  endtask

  task automatic chk_zero(input int d, input int n, input string tag);
    chk({tag, "_ready"}, rdy(d), 0);
    chk({tag, "_busy"},  bsy(d), 0);
    chk({tag, "_done"},  dn(d),  0);
    chk({tag, "_ovf"},   ov(d),  0);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) chk({tag, "_gram"}, el(d, i, j), 0);
  endtask

  // One frame: start, feed samples (optional random gaps and stray I_start),
  // wait for O_done and compare the result against the scoreboard.
  task automatic run_frame(input int d, input int n, input int len, input int accw,
                           input int smp[$], input int max_gap, input bit noise,
                           input string tag);
    int p, lows, k0, gap, w;
    p = n * (n + 1) / 2;
    model(n, len, accw, smp);
    @(negedge clk) st[d] = 1'b1;
    @(negedge clk) st[d] = noise;
    k0 = cyc;
    chk({tag, "_capt_ready"}, rdy(d), 1);
    for (int s = 0; s < len; s++) begin
      if (s > 0) begin
        lows = 0;
        while (!rdy(d) && lows < 50) begin lows++; @(negedge clk); end
        chk({tag, "_ready_low"}, lows, p);
      end
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin vl[d] = 1'b0; @(negedge clk); end
      for (int k = 0; k < n; k++) dat[k*8 +: 8] = smp[s*n+k][7:0];
      vl[d] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vl[d] = (max_gap == 0) && (s < len - 1);
      if (s == len - 1) st[d] = 1'b0;
    end
    w = 0;
    while (!dn(d) && w < 200) begin w++; @(negedge clk); end
    chk({tag, "_done_seen"}, dn(d), 1);
    if (max_gap == 0) chk({tag, "_done_time"}, cyc - k0, len * (p + 1));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) chk({tag, "_gram"}, el(d, i, j), exq.pop_front());
    chk({tag, "_ovf"}, ov(d), exq.pop_front());
    @(negedge clk);
    chk({tag, "_done_pulse"}, dn(d), 0);
    chk({tag, "_idle_busy"}, bsy(d), 0);
  endtask

  initial begin
    int q0[$];
    int qs[$];
    int q3[$];
    q0 = '{1, 2, 3, 4, 5, 6, 7, 8};
    qs = '{255, 255, 255, 255};
    q3 = '{1, 2, 3};
    errors = 0; checks = 0; cyc = 0;
    rst = 1'b1; st = '0; vl = '0; dat = '0;
    repeat (2) @(negedge clk);
    chk_zero(0, 2, "rst_d0");
    chk_zero(1, 2, "rst_d1");
    chk_zero(2, 3, "rst_d2");
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 2, 4, 20, q0, 0, 1'b0, "base");

    // I_valid in IDLE must not start or disturb anything
    repeat (3) begin vl[0] = 1'b1; dat = 24'h0A0B0C; @(negedge clk); end
    vl[0] = 1'b0;
    chk("idle_valid_busy", bsy(0), 0);
    chk("idle_valid_ready", rdy(0), 0);
    chk("hold_g00", el(0, 0, 0), 84);
    chk("hold_g01", el(0, 0, 1), 100);
    chk("hold_g10", el(0, 1, 0), 100);
    chk("hold_g11", el(0, 1, 1), 120);

    run_frame(0, 2, 4, 20, q0, 5, 1'b0, "gaps");
    run_frame(0, 2, 4, 20, q0, 2, 1'b1, "noise");

    // Asynchronous reset in the middle of MAC
    @(negedge clk) st[0] = 1'b1;
    @(negedge clk) st[0] = 1'b0; dat[15:0] = 16'h0201; vl[0] = 1'b1;
    @(posedge clk);
    @(negedge clk) vl[0] = 1'b0;
    chk("pre_rst_busy", bsy(0), 1);
    #2 rst = 1'b1;
    #1 chk_zero(0, 2, "mid_rst");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    run_frame(0, 2, 4, 20, q0, 0, 1'b0, "after_rst");

    run_frame(1, 2, 2, 16, qs, 0, 1'b0, "sat");
    @(negedge clk) st[1] = 1'b1;
    @(negedge clk) st[1] = 1'b0;
    chk("clr_ovf", ov(1), 0);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) chk("clr_gram", el(1, i, j), 0);

    run_frame(2, 3, 1, 20, q3, 0, 1'b0, "n3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
